// File: rtl/move_scheduler.sv
// Purpose: arbitrates one-shot move commands and gravity drops into a single op stream for game_control.
// Latency: cmd pulse to op_valid is 2 cycles when idle; at least one idle cycle separates successive ops.
// Backpressure: an offered op is held stable until op_ready; requests arriving meanwhile stay pending.
//
// Ports:
//   clk, rst_n                   game clock, async active-low reset
//   tick_game, enable            frame strobe, game-running qualifier
//   cmd_left/right/down/rotate/drop  one-cycle move request pulses
//   lines_valid, lines_cleared   line-clear report from the last lock (0..4)
//   op_valid, op_code, op_ready  operation handshake towards game_control
//   level, gravity_period        current level (saturating at 15) and gravity reload value
module move_scheduler #(
  parameter int GRAVITY_BASE    = 48,
  parameter int GRAVITY_STEP    = 3,
  parameter int GRAVITY_MIN     = 2,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_game,
  input  logic       enable,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic       cmd_down,
  input  logic       cmd_rotate,
  input  logic       cmd_drop,
  input  logic       lines_valid,
  input  logic [2:0] lines_cleared,
  output logic       op_valid,
  output logic [2:0] op_code,
  input  logic       op_ready,
  output logic [3:0] level,
  output logic [5:0] gravity_period
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_ROT   = 3'd3;
  localparam logic [2:0] OP_SOFT  = 3'd4;
  localparam logic [2:0] OP_GRAV  = 3'd5;
  localparam logic [2:0] OP_HARD  = 3'd6;

  // Pending-bit positions
  localparam int P_LEFT  = 0;
  localparam int P_RIGHT = 1;
  localparam int P_ROT   = 2;
  localparam int P_DOWN  = 3;
  localparam int P_GRAV  = 4;
  localparam int P_DROP  = 5;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t     state_q, state_d;
  logic [5:0] pend_q, pend_set, pend_clr;
  logic [5:0] grav_cnt;
  logic       grav_reload;
  logic       grav_expire;
  logic       op_valid_d;
  logic [2:0] op_code_d;
  logic [2:0] sel_code;
  logic       lr_conflict;
  logic [3:0] lines_in_level;
  logic [2:0] lines_clamped;
  logic [4:0] lines_sum;
  logic [5:0] period_calc;
  int         step_total;

  // A grant-time reload supersedes an expiry landing in the same cycle.
  assign grav_expire = enable && tick_game && (grav_cnt == 6'd1) && !grav_reload;

  assign pend_set = enable ? {cmd_drop, grav_expire, cmd_down, cmd_rotate, cmd_right, cmd_left}
                           : 6'b0;

  // Priority select; simultaneous left+right cancel each other.
  always_comb begin
    sel_code    = OP_NONE;
    lr_conflict = 1'b0;
    if (pend_q[P_DROP])                         sel_code = OP_HARD;
    else if (pend_q[P_ROT])                     sel_code = OP_ROT;
    else if (pend_q[P_LEFT] && pend_q[P_RIGHT]) lr_conflict = 1'b1;
    else if (pend_q[P_LEFT])                    sel_code = OP_LEFT;
    else if (pend_q[P_RIGHT])                   sel_code = OP_RIGHT;
    else if (pend_q[P_DOWN])                    sel_code = OP_SOFT;
    else if (pend_q[P_GRAV])                    sel_code = OP_GRAV;
  end

  always_comb begin
    state_d     = state_q;
    op_valid_d  = op_valid;
    op_code_d   = op_code;
    pend_clr    = 6'b0;
    grav_reload = 1'b0;
    case (state_q)
      IDLE: begin
        if (!enable) begin
          pend_clr = 6'b111111;
        end else if (lr_conflict) begin
          pend_clr[P_LEFT]  = 1'b1;
          pend_clr[P_RIGHT] = 1'b1;
        end else if (sel_code != OP_NONE) begin
          op_valid_d = 1'b1;
          op_code_d  = sel_code;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          op_code_d  = OP_NONE;
          state_d    = IDLE;
          case (op_code)
            OP_LEFT:  pend_clr[P_LEFT]  = 1'b1;
            OP_RIGHT: pend_clr[P_RIGHT] = 1'b1;
            OP_ROT:   pend_clr[P_ROT]   = 1'b1;
            OP_SOFT: begin
              pend_clr[P_DOWN] = 1'b1;
              pend_clr[P_GRAV] = 1'b1;
              grav_reload      = 1'b1;
            end
            OP_GRAV:  pend_clr[P_GRAV]  = 1'b1;
            OP_HARD: begin
              pend_clr[P_DROP] = 1'b1;
              pend_clr[P_DOWN] = 1'b1;
              pend_clr[P_GRAV] = 1'b1;
              grav_reload      = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set wins over clear so a pulse arriving in the grant cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_valid <= 1'b0;
      op_code  <= OP_NONE;
      pend_q   <= 6'b0;
    end else begin
      state_q  <= state_d;
      op_valid <= op_valid_d;
      op_code  <= op_code_d;
      pend_q   <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  // Gravity counter: a new period only takes effect at the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grav_cnt <= 6'(GRAVITY_BASE);
    end else if (grav_reload) begin
      grav_cnt <= gravity_period;
    end else if (enable && tick_game) begin
      grav_cnt <= (grav_cnt == 6'd1) ? gravity_period : grav_cnt - 6'd1;
    end
  end

  always_comb begin
    lines_clamped = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
    lines_sum     = 5'(lines_in_level) + 5'(lines_clamped);
    step_total    = GRAVITY_STEP * int'(level);
    if (step_total + GRAVITY_MIN >= GRAVITY_BASE) period_calc = 6'(GRAVITY_MIN);
    else                                          period_calc = 6'(GRAVITY_BASE - step_total);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level          <= 4'd0;
      lines_in_level <= 4'd0;
      gravity_period <= 6'(GRAVITY_BASE);
    end else begin
      gravity_period <= period_calc;
      if (lines_valid) begin
        if (lines_sum >= 5'(LINES_PER_LEVEL)) begin
          lines_in_level <= 4'(lines_sum - 5'(LINES_PER_LEVEL));
          if (level != 4'd15) level <= level + 4'd1;
        end else begin
          lines_in_level <= 4'(lines_sum);
        end
      end
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Purpose: directed self-checking bench for move_scheduler.
// Inputs change 1 time unit after the rising edge; outputs are read at the same point.
// Accepted ops are tallied per op_code by a monitor on the rising edge.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick_game = 1'b0;
  logic       enable = 1'b1;
  logic       cmd_left = 1'b0, cmd_right = 1'b0, cmd_down = 1'b0;
  logic       cmd_rotate = 1'b0, cmd_drop = 1'b0;
  logic       lines_valid = 1'b0;
  logic [2:0] lines_cleared = 3'd0;
  logic       op_valid;
  logic [2:0] op_code;
  logic       op_ready = 1'b0;
  logic [3:0] level;
  logic [5:0] gravity_period;

  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt [0:7];

  move_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick_game(tick_game), .enable(enable),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_down(cmd_down),
    .cmd_rotate(cmd_rotate), .cmd_drop(cmd_drop),
    .lines_valid(lines_valid), .lines_cleared(lines_cleared),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .level(level), .gravity_period(gravity_period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && op_valid && op_ready) acc_cnt[op_code] = acc_cnt[op_code] + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    for (int i = 0; i < 8; i++) acc_cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    enable = 1'b1;
    step(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_game = 1'b1;
      step(1);
      tick_game = 1'b0;
      step(3);
    end
  endtask

  task automatic lines(input int v);
    lines_cleared = 3'(v);
    lines_valid = 1'b1;
    step(1);
    lines_valid = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step(2);
    n_checks++; if (op_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", op_valid); else n_pass++;
    n_checks++; if (op_code !== 3'd0) $display("FAIL rst_code: got %0d want 0", op_code); else n_pass++;
    n_checks++; if (level !== 4'd0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (gravity_period !== 6'd48) $display("FAIL rst_period: got %0d want 48", gravity_period); else n_pass++;
    rst_n = 1'b1;
    step(3);
    n_checks++; if (op_valid !== 1'b0) $display("FAIL rst_idle_valid: got %b want 0", op_valid); else n_pass++;
  endtask

  task automatic test_single_rotate();
    do_reset();
    clear_acc();
    op_ready = 1'b1;
    cmd_rotate = 1'b1;
    step(1);
    cmd_rotate = 1'b0;
    n_checks++; if (op_valid !== 1'b0) $display("FAIL rot_c1_valid: got %b want 0", op_valid); else n_pass++;
    step(1);
    n_checks++; if (op_valid !== 1'b1) $display("FAIL rot_c2_valid: got %b want 1", op_valid); else n_pass++;
    n_checks++; if (op_code !== 3'd3) $display("FAIL rot_c2_code: got %0d want 3", op_code); else n_pass++;
    step(1);
    n_checks++; if (op_valid !== 1'b0) $display("FAIL rot_c3_valid: got %b want 0", op_valid); else n_pass++;
    n_checks++; if (op_code !== 3'd0) $display("FAIL rot_c3_code: got %0d want 0", op_code); else n_pass++;
    step(5);
    n_checks++; if (acc_cnt[3] !== 1) $display("FAIL rot_count: got %0d want 1", acc_cnt[3]); else n_pass++;
  endtask

  task automatic test_priority();
    logic       exp_v [1:8];
    logic [2:0] exp_c [1:8];
    exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_c = '{3'd0, 3'd6, 3'd0, 3'd3, 3'd0, 3'd1, 3'd0, 3'd0};
    do_reset();
    op_ready = 1'b1;
    cmd_drop = 1'b1; cmd_rotate = 1'b1; cmd_left = 1'b1;
    step(1);
    cmd_drop = 1'b0; cmd_rotate = 1'b0; cmd_left = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      n_checks++; if (op_valid !== exp_v[c]) $display("FAIL prio_valid c%0d: got %b want %b", c, op_valid, exp_v[c]); else n_pass++;
      n_checks++; if (op_code !== exp_c[c]) $display("FAIL prio_code c%0d: got %0d want %0d", c, op_code, exp_c[c]); else n_pass++;
      step(1);
    end
  endtask

  task automatic test_gravity();
    do_reset();
    clear_acc();
    op_ready = 1'b1;
    ticks(47);
    n_checks++; if (acc_cnt[5] !== 0) $display("FAIL grav_47: got %0d ops want 0", acc_cnt[5]); else n_pass++;
    ticks(1);
    n_checks++; if (acc_cnt[5] !== 1) $display("FAIL grav_48: got %0d ops want 1", acc_cnt[5]); else n_pass++;
    ticks(40);
    n_checks++; if (acc_cnt[5] !== 1) $display("FAIL grav_40: got %0d ops want 1", acc_cnt[5]); else n_pass++;
    cmd_down = 1'b1;
    step(1);
    cmd_down = 1'b0;
    step(4);
    n_checks++; if (acc_cnt[4] !== 1) $display("FAIL grav_soft: got %0d ops want 1", acc_cnt[4]); else n_pass++;
    ticks(47);
    n_checks++; if (acc_cnt[5] !== 1) $display("FAIL grav_reload47: got %0d ops want 1", acc_cnt[5]); else n_pass++;
    ticks(1);
    n_checks++; if (acc_cnt[5] !== 2) $display("FAIL grav_reload48: got %0d ops want 2", acc_cnt[5]); else n_pass++;
  endtask

  task automatic test_lr_conflict();
    do_reset();
    clear_acc();
    op_ready = 1'b1;
    cmd_left = 1'b1; cmd_right = 1'b1;
    step(1);
    cmd_left = 1'b0; cmd_right = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (op_valid !== 1'b0) $display("FAIL lr_valid c%0d: got %b want 0", c, op_valid); else n_pass++;
      step(1);
    end
    cmd_down = 1'b1;
    step(1);
    cmd_down = 1'b0;
    step(1);
    n_checks++; if (op_valid !== 1'b1) $display("FAIL lr_after_valid: got %b want 1", op_valid); else n_pass++;
    n_checks++; if (op_code !== 3'd4) $display("FAIL lr_after_code: got %0d want 4", op_code); else n_pass++;
    step(3);
    n_checks++; if (acc_cnt[1] + acc_cnt[2] !== 0) $display("FAIL lr_none: got %0d L/R ops want 0", acc_cnt[1] + acc_cnt[2]); else n_pass++;
  endtask

  task automatic test_levels();
    int exp_lvl;
    do_reset();
    lines(4); lines(4);
    n_checks++; if (level !== 4'd0) $display("FAIL lvl_8lines: got %0d want 0", level); else n_pass++;
    lines(4);
    n_checks++; if (level !== 4'd1) $display("FAIL lvl_12lines: got %0d want 1", level); else n_pass++;
    n_checks++; if (gravity_period !== 6'd45) $display("FAIL per_lvl1: got %0d want 45", gravity_period); else n_pass++;
    lines(4);
    n_checks++; if (level !== 4'd1) $display("FAIL lvl_carry6: got %0d want 1", level); else n_pass++;
    lines(4);
    n_checks++; if (level !== 4'd2) $display("FAIL lvl_carry10: got %0d want 2", level); else n_pass++;
    n_checks++; if (gravity_period !== 6'd42) $display("FAIL per_lvl2: got %0d want 42", gravity_period); else n_pass++;
    repeat (4) begin lines(4); lines(4); lines(2); end
    n_checks++; if (level !== 4'd6) $display("FAIL lvl_6: got %0d want 6", level); else n_pass++;
    n_checks++; if (gravity_period !== 6'd30) $display("FAIL per_lvl6: got %0d want 30", gravity_period); else n_pass++;
    // Values above 4 count as 4, so 7+7+2 is exactly one level.
    exp_lvl = 6;
    repeat (9) begin
      lines(7); lines(7);
      n_checks++; if (level !== 4'(exp_lvl)) $display("FAIL lvl_clamp_mid: got %0d want %0d", level, exp_lvl); else n_pass++;
      lines(2);
      exp_lvl++;
      n_checks++; if (level !== 4'(exp_lvl)) $display("FAIL lvl_clamp_end: got %0d want %0d", level, exp_lvl); else n_pass++;
    end
    n_checks++; if (gravity_period !== 6'd3) $display("FAIL per_lvl15: got %0d want 3", gravity_period); else n_pass++;
    repeat (3) begin lines(4); lines(4); lines(2); end
    n_checks++; if (level !== 4'd15) $display("FAIL lvl_sat: got %0d want 15", level); else n_pass++;
    n_checks++; if (gravity_period !== 6'd3) $display("FAIL per_sat: got %0d want 3", gravity_period); else n_pass++;
  endtask

  task automatic test_enable_drop();
    do_reset();
    clear_acc();
    op_ready = 1'b0;
    cmd_rotate = 1'b1; cmd_left = 1'b1;
    step(1);
    cmd_rotate = 1'b0; cmd_left = 1'b0;
    step(1);
    n_checks++; if (op_valid !== 1'b1 || op_code !== 3'd3) $display("FAIL en_offer: got %b/%0d want 1/3", op_valid, op_code); else n_pass++;
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cmd_drop = (c == 3);
      step(1);
      n_checks++; if (op_valid !== 1'b1) $display("FAIL en_hold_valid c%0d: got %b want 1", c, op_valid); else n_pass++;
      n_checks++; if (op_code !== 3'd3) $display("FAIL en_hold_code c%0d: got %0d want 3", c, op_code); else n_pass++;
    end
    cmd_drop = 1'b0;
    op_ready = 1'b1;
    step(1);
    n_checks++; if (op_valid !== 1'b0) $display("FAIL en_accept: got %b want 0", op_valid); else n_pass++;
    step(3);
    enable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(1);
      n_checks++; if (op_valid !== 1'b0) $display("FAIL en_quiet c%0d: got %b want 0", c, op_valid); else n_pass++;
    end
    n_checks++; if (acc_cnt[3] !== 1 || acc_cnt[1] !== 0 || acc_cnt[6] !== 0)
      $display("FAIL en_counts: got rot %0d left %0d drop %0d want 1 0 0", acc_cnt[3], acc_cnt[1], acc_cnt[6]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    op_ready = 1'b0;
    lines(4); lines(4); lines(4);
    cmd_rotate = 1'b1;
    step(1);
    cmd_rotate = 1'b0;
    step(1);
    n_checks++; if (op_valid !== 1'b1 || op_code !== 3'd3 || level !== 4'd1)
      $display("FAIL mid_pre: got %b/%0d/lvl%0d want 1/3/lvl1", op_valid, op_code, level);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (op_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", op_valid); else n_pass++;
    n_checks++; if (op_code !== 3'd0) $display("FAIL mid_code: got %0d want 0", op_code); else n_pass++;
    n_checks++; if (level !== 4'd0) $display("FAIL mid_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (gravity_period !== 6'd48) $display("FAIL mid_period: got %0d want 48", gravity_period); else n_pass++;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    clear_acc();
    test_reset();
    test_single_rotate();
    test_priority();
    test_gravity();
    test_lr_conflict();
    test_levels();
    test_enable_drop();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sits between input_manager / gravity timing and game_control, in the game clock domain.
- Latches one-shot move commands and internally generated gravity drops as pending requests.
- Issues exactly one operation at a time to game_control over a valid/ready handshake.
- Tracks cleared lines to derive level and gravity period.

Parameters:
GRAVITY_BASE, 48, gravity period in game ticks at level 0
GRAVITY_STEP, 3, ticks subtracted from period per level
GRAVITY_MIN, 2, floor on gravity period (ticks)
LINES_PER_LEVEL, 10, cleared lines needed per level increment

Ports:
clk  in  1  game clock
rst_n  in  1  reset; asynchronous, active-low
tick_game  in  1  one-cycle 60 Hz frame strobe
enable  in  1  1 = game running (not game_over)
cmd_left  in  1  one-cycle request pulse
cmd_right  in  1  one-cycle request pulse
cmd_down  in  1  soft-drop request pulse
cmd_rotate  in  1  rotate request pulse
cmd_drop  in  1  hard-drop request pulse
lines_valid  in  1  pulse: lines_cleared is valid
lines_cleared  in  3  lines cleared by last lock, 0..4
op_valid  out  1  operation offered to game_control
op_code  out  3  0 NONE, 1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFT_DOWN, 5 GRAVITY, 6 HARD_DROP
op_ready  in  1  game_control accepts op this cycle
level  out  4  current level, saturates at 15
gravity_period  out  6  current reload value in ticks

Behaviour:
- Reset (async, rst_n=0): op_valid=0, op_code=0, level=0, gravity_period=GRAVITY_BASE, all pending bits 0, lines_in_level=0, gravity counter=GRAVITY_BASE, FSM=IDLE.
- Pending capture: each cmd_* pulse with enable=1 sets its pending bit at the next edge. When enable=0, pulses are ignored.
- Gravity: counter decrements on tick_game while enable=1. On tick_game at counter==1, the counter reloads to gravity_period and pend_grav is set. The counter is frozen while enable=0.
- FSM states:
  - IDLE: if any pending bit is set and enable=1, select by priority, latch op_code, assert op_valid at the next edge, go to ISSUE.
  - ISSUE: op_valid and op_code held stable. When op_ready=1, clear the granted pending bit, op_valid=0, op_code=0 at the next edge, and return to IDLE.
- Minimum spacing: one idle cycle between successive ops. Latency from cmd pulse to op_valid is 2 cycles when idle.
- Priority: HARD_DROP > ROTATE > LEFT/RIGHT > SOFT_DOWN > GRAVITY.
- Left and right both pending at selection: clear both and issue nothing that cycle.
- Grant side effects:
  - HARD_DROP: also clears pend_down and pend_grav, and reloads the gravity counter.
  - SOFT_DOWN: clears pend_grav and reloads the gravity counter.
  - GRAVITY: no extra action.
- Set/clear collision: a new pulse of the same type in the grant cycle leaves the bit set; set wins. Duplicate pulses while already pending merge into one.
- enable falling during ISSUE: the op stays offered until op_ready (handshake never retracted). Remaining pending bits are cleared when enable=0 and FSM=IDLE.
- Level accounting on lines_valid (values >4 treated as 4):
  - sum = lines_in_level + lines_cleared.
  - If sum >= LINES_PER_LEVEL: lines_in_level = sum - LINES_PER_LEVEL and level++, saturating at 15. lines_in_level still wraps at 15.
  - Otherwise lines_in_level = sum.
- gravity_period is registered: max(GRAVITY_BASE - level*GRAVITY_STEP, GRAVITY_MIN), updated the cycle after level changes. A new period applies only at the next counter reload, never mid-count.
- op_code is 0 whenever op_valid=0.

Test Plan:
- Reset mid-ISSUE (op_valid=1, code 3) -> op_valid=0, code 0, level 0, gravity_period 48 immediately, with no clock edge needed.
- cmd_rotate pulse at cycle 0, op_ready tied 1 -> op_valid=1, code 3 at cycle 2, deasserted at cycle 3; a single op only.
- cmd_drop, cmd_rotate and cmd_left in the same cycle, op_ready=1 -> ops issued in order 6, 3, 1, each separated by one idle cycle.
- 48 tick_game strobes with no input -> exactly one GRAVITY op. A cmd_down granted at tick 40 -> no GRAVITY until 48 ticks after the grant.
- cmd_left and cmd_right in the same cycle -> no op issued, both pending cleared; op_valid remains 0 for 5 cycles.
- lines_valid pulses of 4, 4, 4 -> level 1, lines_in_level 2, gravity_period 45. Then 5 levels further -> 30. Drive level to 15 -> period 3; additional lines keep level at 15.
- op_ready held 0 for 10 cycles while enable drops -> op_valid and op_code stable throughout; after accept, no further ops issue.
